// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: write-operation codes and their width.
package reg_bank_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b001;
    localparam logic [OP_W-1:0] OP_INC  = 3'b010;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOP  = 3'b110;

    // Codes 110 and 111 both do nothing.
    function automatic logic op_is_nop(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction
endpackage

// File: rtl/reg_bank_alu.sv
// Combinational in-place operation unit for the register bank write port.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] old,
    input  logic [WIDTH-1:0] wdata,
    input  logic [OP_W-1:0]  wop,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_out
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        result    = old;
        carry_out = 1'b0;
        case (wop)
            OP_LOAD: result = wdata;
            OP_CLR:  result = '0;
            OP_INC: begin
                result    = old + ONE;
                carry_out = &old;
            end
            OP_DEC: begin
                result    = old - ONE;
                carry_out = ~|old;
            end
            OP_SHL: begin
                result    = {old[WIDTH-2:0], 1'b0};
                carry_out = old[WIDTH-1];
            end
            OP_SHR: begin
                result    = {1'b0, old[WIDTH-1:1]};
                carry_out = old[0];
            end
            default: result = old;
        endcase
    end

    assign zero_out = (result == '0);
endmodule

// File: rtl/reg_bank_n.sv
// Architectural register file: DEPTH x WIDTH registers, one operate-in-place write
// port, two combinational read ports with optional forwarding, registered flags.
module reg_bank_n
    import reg_bank_pkg::*;
#(
    parameter int  WIDTH    = 6,
    parameter int  DEPTH    = 4,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [OP_W-1:0]  wop,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             carry,
    output logic             zero
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             carry_q;
    logic             zero_q;

    logic             waddr_ok;
    logic             wr_eff;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] regs_d;
    logic             carry_d;
    logic             zero_d;
    logic [DEPTH-1:0] wr_sel;

    assign waddr_ok = (int'(waddr) < DEPTH) && !((ZERO_REG != 0) && (waddr == '0));
    assign wr_eff   = we && !op_is_nop(wop) && waddr_ok;
    assign old_val  = waddr_ok ? regs_q[waddr] : '0;

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .old       (old_val),
        .wdata     (wdata),
        .wop       (wop),
        .result    (regs_d),
        .carry_out (carry_d),
        .zero_out  (zero_d)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_sel[gi] = wr_eff && (waddr == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    regs_q[gi] <= regs_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (wr_eff) begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;

    // Both read ports share one decode: out-of-range and hardwired-zero reads give 0,
    // a matching pending write is forwarded when BYPASS is set.
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];

    assign rd_addr[0] = raddr_a;
    assign rd_addr[1] = raddr_b;
    assign rdata_a    = rd_data[0];
    assign rdata_b    = rd_data[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = '0;
                if ((int'(rd_addr[gi]) < DEPTH) &&
                    !((ZERO_REG != 0) && (rd_addr[gi] == '0))) begin
                    if ((BYPASS != 0) && wr_eff && (rd_addr[gi] == waddr)) begin
                        rd_data[gi] = regs_d;
                    end else begin
                        rd_data[gi] = regs_q[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_reg_bank_n.sv
// Directed, table-driven check of reg_bank_n in forwarding, non-forwarding and
// hardwired-zero/odd-depth configurations.
module tb_reg_bank_n;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       we;
    logic [2:0] wop;
    logic [1:0] waddr;
    logic [5:0] wdata;
    logic [1:0] raddr_a, raddr_b;
    logic [5:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic       carry, zero, nb_carry, nb_zero;

    logic       z_we;
    logic [2:0] z_wop;
    logic [2:0] z_waddr;
    logic [5:0] z_wdata;
    logic [2:0] z_raddr_a, z_raddr_b;
    logic [5:0] z_rdata_a, z_rdata_b;
    logic       z_carry, z_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_bank_n #(.WIDTH(6), .DEPTH(4), .BYPASS(1), .ZERO_REG(0)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .wop(wop), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .carry(carry), .zero(zero)
    );

    reg_bank_n #(.WIDTH(6), .DEPTH(4), .BYPASS(0), .ZERO_REG(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .wop(wop), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(nb_rdata_a), .raddr_b(raddr_b), .rdata_b(nb_rdata_b),
        .carry(nb_carry), .zero(nb_zero)
    );

    reg_bank_n #(.WIDTH(6), .DEPTH(5), .BYPASS(1), .ZERO_REG(1)) u_zr (
        .clk(clk), .rst_n(rst_n), .we(z_we), .wop(z_wop), .waddr(z_waddr), .wdata(z_wdata),
        .raddr_a(z_raddr_a), .rdata_a(z_rdata_a), .raddr_b(z_raddr_b), .rdata_b(z_rdata_b),
        .carry(z_carry), .zero(z_zero)
    );

    typedef struct packed {
        logic       we;
        logic [2:0] wop;
        logic [1:0] waddr;
        logic [5:0] wdata;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [5:0] ea;     // forwarding port A, before the edge
        logic [5:0] eb;     // forwarding port B, before the edge
        logic [5:0] ea_nb;  // non-forwarding port A, before the edge
        logic       ec;     // carry after the edge
        logic       ez;     // zero after the edge
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic idle_inputs();
        we = 1'b0; wop = 3'b110; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        z_we = 1'b0; z_wop = 3'b110; z_waddr = '0; z_wdata = '0; z_raddr_a = '0; z_raddr_b = '0;
    endtask

    task automatic z_op(input logic [2:0] op, input logic [2:0] addr, input logic [5:0] data);
        @(negedge clk);
        z_we = 1'b1; z_wop = op; z_waddr = addr; z_wdata = data;
        @(posedge clk); #1;
        z_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                we    wop     wa     wdata      ra     rb     ea         eb         ea_nb      c     z
        vecs[0]  = '{1'b1, 3'b000, 2'd2, 6'b001100, 2'd2, 2'd0, 6'b001100, 6'b000000, 6'b000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 2'd2, 6'b111111, 2'd2, 2'd2, 6'b001100, 6'b001100, 6'b001100, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 2'd3, 6'b111111, 2'd3, 2'd2, 6'b111111, 6'b001100, 6'b000000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 3'b010, 2'd3, 6'b000000, 2'd3, 2'd3, 6'b000000, 6'b000000, 6'b111111, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 3'b011, 2'd3, 6'b000000, 2'd3, 2'd2, 6'b111111, 6'b001100, 6'b000000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'b000, 2'd1, 6'b100101, 2'd1, 2'd3, 6'b100101, 6'b111111, 6'b000000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'b100, 2'd1, 6'b000000, 2'd1, 2'd1, 6'b001010, 6'b001010, 6'b100101, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 3'b101, 2'd1, 6'b000000, 2'd1, 2'd2, 6'b000101, 6'b001100, 6'b001010, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'b101, 2'd1, 6'b000000, 2'd1, 2'd3, 6'b000010, 6'b111111, 6'b000101, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'b110, 2'd1, 6'b111111, 2'd1, 2'd1, 6'b000010, 6'b000010, 6'b000010, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 3'b000, 2'd2, 6'b000000, 2'd2, 2'd0, 6'b001100, 6'b000000, 6'b001100, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 3'b111, 2'd3, 6'b000000, 2'd3, 2'd1, 6'b111111, 6'b000010, 6'b111111, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 3'b001, 2'd2, 6'b101010, 2'd2, 2'd1, 6'b000000, 6'b000010, 6'b001100, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 3'b010, 2'd1, 6'b000000, 2'd1, 2'd2, 6'b000011, 6'b000000, 6'b000010, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 3'b011, 2'd2, 6'b000000, 2'd2, 2'd2, 6'b111111, 6'b111111, 6'b000000, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 3'b000, 2'd0, 6'b000000, 2'd0, 2'd1, 6'b000000, 6'b000011, 6'b000000, 1'b0, 1'b1};

        idle_inputs();
        rst_n = 1'b0;
        #13;
        raddr_a = 2'd1; raddr_b = 2'd3; #1;
        check("por_rdata_a", rdata_a, 6'd0);
        check("por_rdata_b", rdata_b, 6'd0);
        check("por_carry", {5'd0, carry}, 6'd0);
        check("por_zero", {5'd0, zero}, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we = vecs[i].we; wop = vecs[i].wop; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            #1;
            $display("vec %0d: we=%b wop=%b wa=%0d wd=%b ra=%0d rb=%0d -> a=%b b=%b nb_a=%b",
                     i, we, wop, waddr, wdata, raddr_a, raddr_b, rdata_a, rdata_b, nb_rdata_a);
            check($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].ea);
            check($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].eb);
            check($sformatf("vec%0d_nb_rdata_a", i), nb_rdata_a, vecs[i].ea_nb);
            @(posedge clk); #1;
            check($sformatf("vec%0d_carry", i), {5'd0, carry}, {5'd0, vecs[i].ec});
            check($sformatf("vec%0d_zero", i), {5'd0, zero}, {5'd0, vecs[i].ez});
        end

        // Back-to-back INC on r1 (000011) over three edges.
        @(negedge clk);
        we = 1'b1; wop = 3'b010; waddr = 2'd1; raddr_a = 2'd1; raddr_b = 2'd1;
        repeat (3) @(posedge clk);
        #1; we = 1'b0; #1;
        $display("b2b inc: r1=%b carry=%b zero=%b", nb_rdata_a, carry, zero);
        check("b2b_inc_r1", nb_rdata_a, 6'b000110);
        check("b2b_inc_carry", {5'd0, carry}, 6'd0);

        // Hold for three cycles with we=0 and garbage data, dual-read same register.
        @(negedge clk);
        wop = 3'b001; waddr = 2'd1; wdata = 6'b101101;
        repeat (3) @(posedge clk);
        #1;
        $display("hold: a=%b b=%b carry=%b zero=%b", rdata_a, rdata_b, carry, zero);
        check("hold_r1_a", rdata_a, 6'b000110);
        check("hold_r1_b", rdata_b, 6'b000110);
        check("hold_zero", {5'd0, zero}, 6'd0);

        // Hardwired zero register and out-of-range addresses on DEPTH=5 instance.
        z_op(3'b000, 3'd4, 6'b000000);
        check("zr_load_r4_zero", {5'd0, z_zero}, 6'd1);
        @(negedge clk);
        z_we = 1'b1; z_wop = 3'b000; z_waddr = 3'd0; z_wdata = 6'b111100;
        z_raddr_a = 3'd0; z_raddr_b = 3'd0; #1;
        check("zr_r0_bypass", z_rdata_a, 6'd0);
        @(posedge clk); #1; z_we = 1'b0; #1;
        $display("zr r0 load: r0=%b carry=%b zero=%b", z_rdata_a, z_carry, z_zero);
        check("zr_r0_stored", z_rdata_b, 6'd0);
        check("zr_r0_flags_zero", {5'd0, z_zero}, 6'd1);
        z_op(3'b000, 3'd4, 6'b101010);
        z_raddr_a = 3'd4; #1;
        check("zr_r4_load", z_rdata_a, 6'b101010);
        z_op(3'b001, 3'd6, 6'b000000);
        z_raddr_b = 3'd7; #1;
        $display("zr oob: r4=%b r7=%b zero=%b", z_rdata_a, z_rdata_b, z_zero);
        check("zr_oob_r4_held", z_rdata_a, 6'b101010);
        check("zr_oob_zero_held", {5'd0, z_zero}, 6'd0);
        check("zr_read_r7", z_rdata_b, 6'd0);

        // Asynchronous reset between edges, then release under a pending INC.
        @(negedge clk);
        we = 1'b1; wop = 3'b000; waddr = 2'd1; wdata = 6'b010101;
        @(posedge clk); #1;
        wop = 3'b011; waddr = 2'd0;
        @(posedge clk); #1;
        we = 1'b0; raddr_a = 2'd1; raddr_b = 2'd0; #1;
        check("pre_rst_r1", nb_rdata_a, 6'b010101);
        check("pre_rst_carry", {5'd0, carry}, 6'd1);
        #1; rst_n = 1'b0; #1;
        $display("async rst: a=%b b=%b carry=%b zero=%b", rdata_a, rdata_b, carry, zero);
        check("rst_rdata_a", rdata_a, 6'd0);
        check("rst_rdata_b", rdata_b, 6'd0);
        check("rst_carry", {5'd0, carry}, 6'd0);
        check("rst_zero", {5'd0, zero}, 6'd0);
        @(negedge clk);
        we = 1'b1; wop = 3'b010; waddr = 2'd3; raddr_a = 2'd3; #1;
        check("rst_bypass_pending", rdata_a, 6'b000001);
        check("rst_nob_stored", nb_rdata_a, 6'd0);
        @(posedge clk); #1;
        check("rst_held_no_commit", nb_rdata_a, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; #1;
        $display("rst release: r3=%b carry=%b zero=%b", nb_rdata_a, carry, zero);
        check("release_r3", nb_rdata_a, 6'b000001);
        check("release_zero", {5'd0, zero}, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
